// File: rtl/func_32b_shared_scheduler.sv
// Two-requester scheduler sharing one external function unit: arbitrates in IDLE,
// holds operands for the execute phase, then presents a registered response until it is consumed.
module func_32b_shared_scheduler #(
  parameter int SIZE      = 32,
  parameter int MC_CYCLES = 4
) (
  input  logic            CGRA_Clock,
  input  logic            CGRA_Reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [SIZE-1:0] req0_a,
  input  logic [SIZE-1:0] req0_b,
  input  logic [3:0]      req0_op,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [SIZE-1:0] req1_a,
  input  logic [SIZE-1:0] req1_b,
  input  logic [3:0]      req1_op,
  output logic [SIZE-1:0] alu_a,
  output logic [SIZE-1:0] alu_b,
  output logic [3:0]      alu_select,
  input  logic [SIZE-1:0] alu_out,
  output logic            rsp_valid,
  output logic            rsp_id,
  output logic [SIZE-1:0] rsp_data,
  input  logic            rsp_ready
);

  localparam int            CW     = $clog2(MC_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MC = CW'(MC_CYCLES - 1);
  localparam logic [3:0]    OP_MUL = 4'd1;
  localparam logic [3:0]    OP_DIV = 4'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] alu_a_q, alu_a_d;
  logic [SIZE-1:0] alu_b_q, alu_b_d;
  logic [3:0]      alu_sel_q, alu_sel_d;
  logic            id_q, id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_id_q, rsp_id_d;
  logic [SIZE-1:0] rsp_data_q, rsp_data_d;

  logic            grant_valid_s;
  logic            grant_id_s;
  logic            idle_ok_s;
  logic            accept_s;
  logic [3:0]      sel_op_s;

  // Round-robin choice between the two requesters; a tie goes to the one not served last.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = ~last_grant_q;
    end else if (req0_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b0;
    end else if (req1_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  // Ready depends only on state, reset and valids, never on rsp_ready.
  assign idle_ok_s  = CGRA_Reset && (state_q == IDLE);
  assign accept_s   = idle_ok_s && grant_valid_s;
  assign req0_ready = accept_s && !grant_id_s;
  assign req1_ready = accept_s && grant_id_s;
  assign sel_op_s   = grant_id_s ? req1_op : req0_op;

  // Next-state and datapath update for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          alu_a_d      = grant_id_s ? req1_a : req0_a;
          alu_b_d      = grant_id_s ? req1_b : req0_b;
          alu_sel_d    = sel_op_s;
          id_d         = grant_id_s;
          last_grant_d = grant_id_s;
          if ((sel_op_s == OP_MUL) || (sel_op_s == OP_DIV)) begin
            cnt_d = CNT_MC;
          end else begin
            cnt_d = {CW{1'b0}};
          end
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (cnt_q != {CW{1'b0}}) begin
          cnt_d   = cnt_q - CW'(1'b1);
          state_d = EXEC;
        end else begin
          rsp_data_d  = alu_out;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CGRA_Clock) begin
    if (!CGRA_Reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= {CW{1'b0}};
      alu_a_q      <= {SIZE{1'b0}};
      alu_b_q      <= {SIZE{1'b0}};
      alu_sel_q    <= 4'd0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= {SIZE{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_select = alu_sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_func_32b_shared_scheduler.sv
// Bench for func_32b_shared_scheduler: behavioural function unit, directed cases, then random
// transactions checked against an arbitration/latency model of the scheduler.
module tb_func_32b_shared_scheduler;

  localparam int MC = 4;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_select;
  logic        rsp_valid, rsp_id, rsp_ready;
  logic [31:0] rsp_data;

  int   checks = 0;
  int   errors = 0;
  logic last_g = 1'b1;

  func_32b_shared_scheduler #(.SIZE(32), .MC_CYCLES(MC)) dut (
    .CGRA_Clock(clk), .CGRA_Reset(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a * b;
      4'd2:    return a - b;
      4'd3:    return (b == 32'd0) ? 32'd0 : a / b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return a << b[4:0];
      4'd8:    return $signed(a) >>> b[4:0];
      4'd9:    return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_out = fu(alu_select, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: arbitration, exact execute latency, held response, handshake.
  task automatic txn(input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                     input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                     input int hold);
    logic        g;
    logic [3:0]  op;
    logic [31:0] a, b, exp;
    int          lat;
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    rsp_ready  = 1'b0;
    #1;
    g = (v0 && v1) ? ~last_g : !v0;
    chk("grant_ready0", 32'(req0_ready), 32'(!g));
    chk("grant_ready1", 32'(req1_ready), 32'(g));
    op  = g ? op1 : op0;
    a   = g ? a1 : a0;
    b   = g ? b1 : b0;
    exp = fu(op, a, b);
    lat = (op == 4'd1 || op == 4'd3) ? MC : 1;
    tick();
    for (int i = 0; i < lat; i++) begin
      chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("exec_alu_select", 32'(alu_select), 32'(op));
      chk("exec_alu_a", alu_a, a);
      chk("exec_alu_b", alu_b, b);
      chk("exec_ready", 32'({req0_ready, req1_ready}), 32'd0);
      tick();
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_id", 32'(rsp_id), 32'(g));
    chk("rsp_data", rsp_data, exp);
    for (int i = 0; i < hold; i++) begin
      chk("hold_ready", 32'({req0_ready, req1_ready}), 32'd0);
      tick();
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_id", 32'(rsp_id), 32'(g));
      chk("hold_rsp_data", rsp_data, exp);
    end
    rsp_ready = 1'b1;
    #1;
    chk("handshake_ready", 32'({req0_ready, req1_ready}), 32'd0);
    tick();
    rsp_ready = 1'b0;
    chk("after_rsp_valid", 32'(rsp_valid), 32'd0);
    last_g = g;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic        v0, v1;
    logic [3:0]  o0, o1;
    logic [31:0] x0, y0, x1, y1;

    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1'b1; req1_op = 4'd0; req1_a = 32'd3; req1_b = 32'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_alu_select", 32'(alu_select), 32'd0);
    end
    rst_n = 1'b1;
    last_g = 1'b1;

    // Tie after reset: req0 first, then req1.
    txn(1'b1, 4'd2, 32'd10, 32'd3, 1'b1, 4'd6, 32'hF0, 32'h0F, 0);
    txn(1'b1, 4'd2, 32'd10, 32'd3, 1'b1, 4'd6, 32'hF0, 32'h0F, 0);
    txn(1'b1, 4'd0, 32'd5, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0, 0);
    txn(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd1, 32'd6, 32'd7, 0);
    txn(1'b1, 4'd8, 32'h8000_0000, 32'd4, 1'b0, 4'd0, 32'd0, 32'd0, 3);
    txn(1'b1, 4'd12, 32'd123, 32'd45, 1'b0, 4'd0, 32'd0, 32'd0, 0);
    txn(1'b1, 4'd3, 32'd100, 32'd7, 1'b1, 4'd9, 32'hFFFF_0000, 32'd8, 1);

    // Reset in the middle of a divide discards it.
    req0_valid = 1'b1; req0_op = 4'd3; req0_a = 32'd99; req0_b = 32'd9;
    req1_valid = 1'b0;
    #1;
    chk("div_ready0", 32'(req0_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    chk("midrst_alu_select", 32'(alu_select), 32'd0);
    rst_n = 1'b1;
    req0_valid = 1'b0;
    last_g = 1'b1;
    for (int i = 0; i < MC + 3; i++) begin
      tick();
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    txn(1'b1, 4'd4, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 4'd5, 32'h1, 32'h2, 0);

    for (int it = 0; it < 40; it++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      o0 = 4'($urandom_range(0, 15));
      o1 = 4'($urandom_range(0, 15));
      x0 = $urandom; x1 = $urandom;
      y0 = (o0 >= 4'd7 && o0 <= 4'd9) ? 32'($urandom_range(0, 31)) : $urandom;
      y1 = (o1 >= 4'd7 && o1 <= 4'd9) ? 32'($urandom_range(0, 31)) : $urandom;
      txn(v0, o0, x0, y0, v1, o1, x1, y1, $urandom_range(0, 3));
    end

    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/func_32b_shared_scheduler.md
FUNC_32B_SHARED_SCHEDULER -- requirements
Module: func_32b_shared_scheduler

Interface
REQ-001 Parameter SIZE, default 32, data width of operands and results.
REQ-002 Parameter MC_CYCLES, default 4, execute cycles for multiply (op 1) and divide (op 3); legal range >= 1.
REQ-003 CGRA_Clock  input  1  sole clock; all state updates on rising edge.
REQ-004 CGRA_Reset  input  1  synchronous, active-low reset.
REQ-005 req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-006 req0_ready / req1_ready  output  1  scheduler accepts requester n this cycle.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  SIZE  operands of requester n.
REQ-008 req0_op / req1_op  input  4  function select: 0 add, 1 mul, 2 sub, 3 div, 4 and, 5 or, 6 xor, 7 shl, 8 ashr, 9 lshr, 10-15 yield zero.
REQ-009 alu_a, alu_b  output  SIZE  operands to the shared function unit.
REQ-010 alu_select  output  4  select to the shared function unit.
REQ-011 alu_out  input  SIZE  combinational result from the shared function unit.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_id  output  1  index of the requester owning the result.
REQ-014 rsp_data  output  SIZE  registered result.
REQ-015 rsp_ready  input  1  consumer takes the result.

Function
REQ-016 FSM states SHALL be IDLE, EXEC, RESP; any other encoding SHALL recover to IDLE on the next edge.
REQ-017 Grant in IDLE: one valid -> that requester; both valid -> requester != last_grant; last_grant reset value 1, so req0 wins the first tie.
REQ-018 reqN_ready SHALL be 1 only in IDLE, only for the granted requester, and both SHALL be 0 in EXEC and RESP.
REQ-019 Accept (valid && ready in IDLE): latch a, b, op, id into operand registers; last_grant <= id; load count <= MC_CYCLES-1 if op is 1 or 3, else 0; go to EXEC.
REQ-020 alu_a, alu_b, alu_select SHALL be driven from the operand registers and SHALL hold stable for the whole EXEC state and keep their last values in IDLE and RESP.
REQ-021 In EXEC with count != 0: count decrements; with count == 0: rsp_data <= alu_out, rsp_id <= latched id, go to RESP.
REQ-022 Latency: request accepted in cycle N -> rsp_valid first high in cycle N+2 (ops other than 1 and 3) or N+1+MC_CYCLES (ops 1, 3).
REQ-023 In RESP rsp_valid SHALL be 1; rsp_data and rsp_id SHALL hold stable until rsp_ready is 1; on that edge go to IDLE and clear rsp_valid.
REQ-024 No request SHALL be accepted in the RESP cycle that completes the handshake; the next accept occurs earliest in the following IDLE cycle (peak throughput one op per 3 cycles).
REQ-025 Ops 10-15 SHALL take the single-cycle path and return the function unit's value (zero).
REQ-026 Requesters SHALL see no combinational path from rsp_ready to reqN_ready.
REQ-027 Count register width SHALL be ceil(log2(MC_CYCLES))+1 bits, enough to hold MC_CYCLES-1 with no wrap.

Reset
REQ-028 With CGRA_Reset == 0 at an edge: state IDLE, last_grant 1, count 0, rsp_valid 0, rsp_id 0, rsp_data 0, alu_a 0, alu_b 0, alu_select 0.
REQ-029 reqN_ready SHALL be 0 in every cycle in which CGRA_Reset is 0.
REQ-030 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response emitted.

Verification (bench drives alu_out from a behavioural model of the 10-op function unit)
REQ-031 req0 op 0, a=5, b=7 at cycle N -> rsp_valid at N+2, rsp_id 0, rsp_data 12.
REQ-032 After reset, both valid in the same cycle (req0 op 2 10-3, req1 op 6 0xF0^0x0F) -> req0 served first (data 7, id 0), then req1 (data 0xFF, id 1).
REQ-033 MC_CYCLES=4, req1 op 1, 6*7 at N -> alu_select=1 stable N+1..N+4, rsp_valid at N+5, data 42, id 1.
REQ-034 rsp_ready held 0 for 3 cycles in RESP -> rsp_valid/data/id constant, both reqN_ready 0; rsp_ready=1 -> IDLE next cycle.
REQ-035 req0 op 12 -> rsp_valid at N+2, rsp_data 0.
REQ-036 CGRA_Reset=0 during EXEC of op 3 -> next cycle rsp_valid 0, state IDLE, no response for that operation ever appears.
